// File: rtl/ebox_clk_gen.sv
// rtl/ebox_clk_gen.sv - EBOX clock-enable generator; readback mux under EBOX_CLK_GEN_DIAG_READ_EN
// Prescaled tick with run/step/burst/error-stop control and per-channel disable mask.
module ebox_clk_gen #(
    parameter int NCH     = 3,
    parameter int BURST_W = 8,
    parameter int RATE_W  = 4
) (
    input  logic               clk,
    input  logic               CROBAR_N,
    input  logic               func_valid,
    input  logic [2:0]         func_code,
    input  logic [BURST_W-1:0] func_data,
    output logic               func_ready,
    input  logic               hold,
    input  logic               err_in,
    input  logic               err_stop_en,
    output logic               tick,
    output logic [NCH-1:0]     ch_en,
    output logic [2:0]         state,
    output logic               err_stop,
    output logic [BURST_W-1:0] burst_cnt,
    input  logic [2:0]         diag_sel,
    output logic [15:0]        diag_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_BURST   = 3'd3,
        S_ERRSTOP = 3'd4
    } state_t;

    localparam logic [2:0] F_START    = 3'd1;
    localparam logic [2:0] F_STOP     = 3'd2;
    localparam logic [2:0] F_STEP     = 3'd3;
    localparam logic [2:0] F_BURST    = 3'd4;
    localparam logic [2:0] F_LD_RATE  = 3'd5;
    localparam logic [2:0] F_LD_BURST = 3'd6;
    localparam logic [2:0] F_LD_DIS   = 3'd7;

    state_t             state_q, state_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic [RATE_W-1:0]  pre_q, pre_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]     dis_q, dis_d;

    logic active;
    logic hit;
    logic err_hit;
    logic accept;
    logic stop_cmd;
    logic tick_int;

    assign active   = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_BURST);
    assign hit      = (pre_q == rate_q);
    assign err_hit  = err_in & err_stop_en;
    assign tick_int = active & hit & ~hold & ~err_hit;

    assign func_ready = !((state_q == S_STEP) || (state_q == S_BURST));
    assign accept     = func_valid & func_ready;
    // STOP bypasses func_ready so a running step/burst can always be aborted
    assign stop_cmd   = func_valid & (func_code == F_STOP);

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q <= S_IDLE;
            rate_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            dis_q   <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            dis_q   <= dis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        dis_d   = dis_q;

        // A hit under hold parks the prescaler at rate so the tick fires once hold drops
        if (active) begin
            if (hit) begin
                pre_d = hold ? pre_q : '0;
            end else begin
                pre_d = pre_q + RATE_W'(1);
            end
        end

        if (tick_int) begin
            if (state_q == S_STEP) begin
                state_d = S_IDLE;
            end else if (state_q == S_BURST) begin
                cnt_d = cnt_q - BURST_W'(1);
                if (cnt_q == BURST_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
        end

        if (active && err_hit) begin
            state_d = S_ERRSTOP;
        end

        if (accept) begin
            case (func_code)
                F_START: begin
                    if (state_q == S_IDLE) begin
                        state_d = S_RUN;
                        pre_d   = '0;
                    end
                end
                F_STEP: begin
                    if (state_q == S_IDLE) begin
                        state_d = S_STEP;
                        pre_d   = '0;
                    end
                end
                F_BURST: begin
                    if ((state_q == S_IDLE) && (cnt_q != '0)) begin
                        state_d = S_BURST;
                        pre_d   = '0;
                    end
                end
                F_LD_RATE: begin
                    rate_d = func_data[RATE_W-1:0];
                    if (state_q == S_RUN) begin
                        pre_d = '0;
                    end
                end
                F_LD_BURST: cnt_d = func_data;
                F_LD_DIS:   dis_d = func_data[NCH-1:0];
                default: ;
            endcase
        end

        if (stop_cmd) begin
            state_d = S_IDLE;
            pre_d   = '0;
        end
    end

    assign tick      = tick_int;
    assign ch_en     = {NCH{tick_int}} & ~dis_q;
    assign state     = state_q;
    assign err_stop  = (state_q == S_ERRSTOP);
    assign burst_cnt = cnt_q;

`ifdef EBOX_CLK_GEN_DIAG_READ_EN
    always_comb begin
        diag_data = '0;
        case (diag_sel)
            3'd0:    diag_data = 16'(cnt_q);
            3'd1:    diag_data = 16'(rate_q);
            3'd2:    diag_data = 16'(dis_q);
            3'd3:    diag_data = 16'({state_q, err_stop, hold, err_in});
            3'd4:    diag_data = 16'(pre_q);
            default: diag_data = '0;
        endcase
    end
`else
    logic diag_unused;
    assign diag_unused = ^diag_sel;
    assign diag_data   = '0;
`endif

endmodule
